// File: rtl/coco_clk_pkg.sv
// rtl/coco_clk_pkg.sv - shared divisor defaults and quarter encoding for the 6809E clock generator
package coco_clk_pkg;

  // Default system clocks per E period (slow / fast) and per pixel enable
  localparam int DEF_DIV_SLOW = 56;
  localparam int DEF_DIV_FAST = 28;
  localparam int DEF_PIX_DIV  = 4;

  // Quarter of the E period the phase counter is in
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quarter_t;

  // Quarter index of a phase; compares against multiples of the quarter length so no divider is built
  function automatic quarter_t quarter_of(input int ph, input int qlen);
    if (ph < qlen)
      return Q0;
    else if (ph < 2 * qlen)
      return Q1;
    else if (ph < 3 * qlen)
      return Q2;
    else
      return Q3;
  endfunction

  // Q is high in the middle two quarters
  function automatic logic q_level(input quarter_t qt);
    return (qt == Q1) || (qt == Q2);
  endfunction

  // E is high in the second half, lagging Q by one quarter
  function automatic logic e_level(input quarter_t qt);
    return (qt == Q2) || (qt == Q3);
  endfunction

endpackage

// File: rtl/coco_clkdiv.sv
// rtl/coco_clkdiv.sv - free-running divider producing a one-cycle enable every DIV clocks
module coco_clkdiv
  import coco_clk_pkg::*;
#(
  parameter int DIV = DEF_PIX_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic ena
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("coco_clkdiv: DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt;

  // Count 0..DIV-1 and fire the enable on the clock after the terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ena <= 1'b0;
    end else begin
      ena <= (cnt == LAST);
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/coco_eq_clkgen.sv
// rtl/coco_eq_clkgen.sv - 6809E E/Q quadrature clock generator with speed switch, stall and pixel enable
module coco_eq_clkgen
  import coco_clk_pkg::*;
#(
  parameter int DIV_SLOW = DEF_DIV_SLOW,
  parameter int DIV_FAST = DEF_DIV_FAST,
  parameter int PIX_DIV  = DEF_PIX_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic speed_req,
  input  logic stall,
  output logic E,
  output logic Q,
  output logic e_rise,
  output logic e_fall,
  output logic q_rise,
  output logic q_fall,
  output logic speed_cur,
  output logic pix_ena
);

  localparam int PH_W      = $clog2(DIV_SLOW);
  localparam int QLEN_SLOW = DIV_SLOW / 4;
  localparam int QLEN_FAST = DIV_FAST / 4;
  localparam logic [PH_W-1:0] LAST_SLOW = PH_W'(DIV_SLOW - 1);
  localparam logic [PH_W-1:0] LAST_FAST = PH_W'(DIV_FAST - 1);

  if ((DIV_SLOW % 4) != 0 || DIV_SLOW < 8) begin : g_bad_slow
    $error("coco_eq_clkgen: DIV_SLOW must be a multiple of 4 and at least 8");
  end
  if ((DIV_FAST % 4) != 0 || DIV_FAST < 8) begin : g_bad_fast
    $error("coco_eq_clkgen: DIV_FAST must be a multiple of 4 and at least 8");
  end
  if (DIV_FAST > DIV_SLOW) begin : g_bad_order
    $error("coco_eq_clkgen: DIV_FAST must not exceed DIV_SLOW");
  end
  if (PIX_DIV < 2) begin : g_bad_pix
    $error("coco_eq_clkgen: PIX_DIV must be at least 2");
  end

  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] p_last;
  int              qlen;
  logic            at_last;
  logic            holding;
  quarter_t        quarter;
  logic            e_next;
  logic            q_next;

  // Period end, stall hold and next E/Q levels for the speed currently in effect
  always_comb begin
    p_last  = speed_cur ? LAST_FAST : LAST_SLOW;
    qlen    = speed_cur ? QLEN_FAST : QLEN_SLOW;
    at_last = (ph == p_last);
    holding = at_last && stall;
    quarter = quarter_of(32'(ph), qlen);
    e_next  = e_level(quarter);
    q_next  = q_level(quarter);
  end

  // Phase counter: wraps at the period end, parks there while stalled, and adopts a new speed only on the wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph        <= '0;
      speed_cur <= 1'b0;
    end else if (at_last) begin
      if (!holding) begin
        ph        <= '0;
        speed_cur <= speed_req;
      end
    end else begin
      ph <= ph + PH_W'(1);
    end
  end

  // Registered E/Q levels one cycle behind ph, with edge strobes coincident with the new level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      E      <= 1'b0;
      Q      <= 1'b0;
      e_rise <= 1'b0;
      e_fall <= 1'b0;
      q_rise <= 1'b0;
      q_fall <= 1'b0;
    end else begin
      E      <= e_next;
      Q      <= q_next;
      e_rise <= e_next & ~E;
      e_fall <= ~e_next & E;
      q_rise <= q_next & ~Q;
      q_fall <= ~q_next & Q;
    end
  end

  // Video clock enable runs free of speed, stall and E/Q phase
  coco_clkdiv #(
    .DIV(PIX_DIV)
  ) u_pix_div (
    .clk  (clk),
    .reset(reset),
    .ena  (pix_ena)
  );

endmodule
